// File: rtl/producer2riscv.sv
`default_nettype none
// ============================================================================
// Module   : producer2riscv
// Purpose  : Circular FIFO that buffers a producer stream for a RISC-V pop port.
// Revision : 1.0
// ============================================================================
module producer2riscv #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  val_in,
  output logic                  ready_upward,
  input  logic                  rd_req,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_err,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full
);

  localparam logic [ADDR_WIDTH:0] c_depth = DEPTH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_rd_err;

  logic w_empty;
  logic w_full;
  logic w_ready;
  logic w_wr_en;
  logic w_rd_en;
  logic w_underflow;

  always_comb begin
    w_empty     = (r_count == '0);
    w_full      = (r_count == c_depth);
    w_ready     = !w_full && !reset;
    w_wr_en     = val_in && w_ready;
    // A pop on an empty FIFO never sees a same-cycle write: no bypass path.
    w_rd_en     = rd_req && !w_empty;
    w_underflow = rd_req && w_empty;
  end

  // Storage is deliberately not reset; stale words are unreachable after reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_en;
      r_rd_err   <= w_underflow;
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_en) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + 1'b1;
      end
      if (w_wr_en && !w_rd_en) begin
        r_count <= r_count + 1'b1;
      end else if (w_rd_en && !w_wr_en) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign ready_upward = w_ready;
  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign rd_err       = r_rd_err;
  assign count        = r_count;
  assign empty        = w_empty;
  assign full         = w_full;

endmodule
`default_nettype wire

// File: tb/tb_producer2riscv.sv
`default_nettype none
// ============================================================================
// Module   : tb_producer2riscv
// Purpose  : Directed self-checking bench for producer2riscv (DEPTH = 4).
// Revision : 1.0
// ============================================================================
module tb_producer2riscv;

  logic        clk;
  logic        reset;
  logic [31:0] din;
  logic        val_in;
  logic        ready_upward;
  logic        rd_req;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rd_err;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  int n_checks;
  int n_pass;
  logic [31:0] q_model [$];
  logic [31:0] w_exp;

  producer2riscv #(
    .DATA_WIDTH(32),
    .DEPTH     (4),
    .ADDR_WIDTH(2)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .val_in      (val_in),
    .ready_upward(ready_upward),
    .rd_req      (rd_req),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_err      (rd_err),
    .count       (count),
    .empty       (empty),
    .full        (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    din      = '0;
    val_in   = 1'b0;
    rd_req   = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_err", rd_err, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_ready", ready_upward, 0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", ready_upward, 1);

    // Scenario 1: three writes then three pops
    val_in = 1'b1;
    din = 32'hA1; tick();
    din = 32'hA2; tick();
    din = 32'hA3; tick();
    val_in = 1'b0;
    check("s1_count3", count, 3);
    for (int i = 0; i < 3; i++) begin
      w_exp = 32'hA1 + i;
      rd_req = 1'b1;
      tick();
      check("s1_rd_valid", rd_valid, 1);
      check("s1_rd_data", rd_data, w_exp);
    end
    rd_req = 1'b0;
    tick();
    check("s1_valid_drop", rd_valid, 0);
    check("s1_count0", count, 0);
    check("s1_empty", empty, 1);

    // Scenario 2: fill, hold extra word while full, pop, then extra accepted
    val_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din = 32'hB0 + i;
      tick();
    end
    din = 32'hFF;
    check("s2_full", full, 1);
    check("s2_ready0", ready_upward, 0);
    tick();
    check("s2_count_hold", count, 4);
    rd_req = 1'b1;
    tick();
    check("s2_pop_only_valid", rd_valid, 1);
    check("s2_pop_only_data", rd_data, 32'hB0);
    check("s2_pop_only_count", count, 3);
    rd_req = 1'b0;
    check("s2_ready1", ready_upward, 1);
    tick();
    val_in = 1'b0;
    check("s2_ff_accepted", count, 4);
    for (int i = 0; i < 4; i++) begin
      w_exp = (i == 3) ? 32'hFF : 32'hB1 + i;
      rd_req = 1'b1;
      tick();
      check("s2_drain", rd_data, w_exp);
    end
    rd_req = 1'b0;
    tick();
    check("s2_empty", empty, 1);

    // Scenario 3: underflow
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("s3_rd_err", rd_err, 1);
    check("s3_rd_valid", rd_valid, 0);
    check("s3_rd_data_hold", rd_data, 32'hFF);
    check("s3_count", count, 0);
    tick();
    check("s3_err_pulse", rd_err, 0);

    // Scenario 4: simultaneous write and pop at count 2
    val_in = 1'b1;
    din = 32'h11; tick();
    din = 32'h22; tick();
    din = 32'h55;
    rd_req = 1'b1;
    tick();
    val_in = 1'b0;
    check("s4_count", count, 2);
    check("s4_oldest", rd_data, 32'h11);
    tick();
    check("s4_second", rd_data, 32'h22);
    tick();
    check("s4_last", rd_data, 32'h55);
    rd_req = 1'b0;
    tick();
    check("s4_empty", empty, 1);

    // Simultaneous write and pop while empty: write only, no bypass
    val_in = 1'b1;
    rd_req = 1'b1;
    din = 32'h66;
    tick();
    val_in = 1'b0;
    rd_req = 1'b0;
    check("se_rd_err", rd_err, 1);
    check("se_rd_valid", rd_valid, 0);
    check("se_no_bypass", rd_data, 32'h55);
    check("se_count", count, 1);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("se_pop", rd_data, 32'h66);

    // Scenario 5: write/pop pairs with random gaps across pointer wrap
    for (int i = 0; i < 10; i++) begin
      val_in = 1'b1;
      din = 32'hC0 + i;
      q_model.push_back(32'hC0 + i);
      tick();
      val_in = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
      w_exp = q_model.pop_front();
      check("s5_valid", rd_valid, 1);
      check("s5_order", rd_data, w_exp);
      repeat ($urandom_range(0, 2)) tick();
    end
    check("s5_empty", empty, 1);

    // Scenario 6: reset with three words stored, inputs active during reset
    val_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 32'hD0 + i;
      tick();
    end
    check("s6_count3", count, 3);
    reset = 1'b1;
    rd_req = 1'b1;
    #1;
    check("s6_ready_in_rst", ready_upward, 0);
    tick();
    check("s6_count0", count, 0);
    check("s6_empty", empty, 1);
    check("s6_rd_valid", rd_valid, 0);
    reset = 1'b0;
    val_in = 1'b0;
    tick();
    rd_req = 1'b0;
    check("s6_post_err", rd_err, 1);
    check("s6_post_valid", rd_valid, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
